// File: rtl/kernel_launcher_pkg.sv
// Shared types and helpers for the kernel launcher.
// Holds the FSM state encoding, default sizing and the argument-index width helper.
package kernel_launcher_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_NARGS = 7;

  // Width of the argument index; a single-argument kernel still needs one bit.
  function automatic int idx_width(input int nargs);
    int w;
    w = $clog2(nargs);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/launcher_edge_det.sv
// Registered rising-edge detector for the kernel done strobe.
// The history register updates every cycle regardless of launcher state.
module launcher_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_i,
  output logic rise_o
);

  logic prev_q;

  // Remember last cycle's level so a held-high strobe yields one edge only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/kernel_launcher.sv
// Upstream driver for an HLS kernel using the r_enable/w_enable start-done handshake.
// Collects NARGS argument words from a stream, pulses start, captures the result on
// the done edge and offers it on a valid/ready output.
// Optional watchdog: define KERNEL_TIMEOUT_EN to abort a WAIT lasting TIMEOUT_CYCLES.
module kernel_launcher
  import kernel_launcher_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int NARGS          = DEFAULT_NARGS,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   arg_valid,
  output logic                   arg_ready,
  input  logic [WIDTH-1:0]       arg_data,
  output logic                   k_r_enable,
  output logic                   k_control_arr,
  output logic [NARGS*WIDTH-1:0] k_init,
  input  logic                   k_w_enable,
  input  logic [WIDTH-1:0]       k_result,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [WIDTH-1:0]       res_data,
  output logic                   res_timeout,
  output logic                   busy
);

  localparam int IDX_W = idx_width(NARGS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NARGS - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] slot_q [NARGS];
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_timeout_q, res_timeout_d;
  logic             r_en_q, r_en_d;
  logic             done_rise;
  logic             arg_fire;
  logic             res_fire;
  logic             expired;

  assign arg_fire = arg_valid && (state_q == LOAD);
  assign res_fire = res_ready && (state_q == DONE);

  launcher_edge_det u_edge_det (
    .clk    (clk),
    .rst_n  (rst_n),
    .sig_i  (k_w_enable),
    .rise_o (done_rise)
  );

`ifdef KERNEL_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counter is zero on the first WAIT cycle; expiry fires on the cycle whose
  // increment would bring it to TIMEOUT_CYCLES, i.e. after TIMEOUT_CYCLES WAIT cycles.
  assign cnt_d   = (state_q == WAIT) ? cnt_q + CNT_W'(1) : '0;
  assign expired = (state_q == WAIT) && (cnt_q == CNT_LAST);

  // Watchdog cycle counter, only meaningful while waiting on the kernel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
  assign expired            = 1'b0;
`endif

  // State, index, result and start-pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= LOAD;
      idx_q         <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      r_en_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      res_data_q    <= res_data_d;
      res_timeout_q <= res_timeout_d;
      r_en_q        <= r_en_d;
    end
  end

  // Next-state logic; the start pulse is registered so it lines up with LAUNCH.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    res_data_d    = res_data_q;
    res_timeout_d = res_timeout_q;
    r_en_d        = 1'b0;
    unique case (state_q)
      LOAD: begin
        if (arg_fire) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = LAUNCH;
            r_en_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      LAUNCH: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A done edge coinciding with watchdog expiry still delivers the result.
        if (done_rise) begin
          res_data_d    = k_result;
          res_timeout_d = 1'b0;
          state_d       = DONE;
        end else if (expired) begin
          res_data_d    = '0;
          res_timeout_d = 1'b1;
          state_d       = DONE;
        end
      end
      DONE: begin
        if (res_fire) begin
          res_timeout_d = 1'b0;
          state_d       = LOAD;
        end
      end
      default: begin
        state_d = LOAD;
      end
    endcase
  end

  // One register per argument slot; each loads only on its own LOAD beat.
  for (genvar gi = 0; gi < NARGS; gi++) begin : g_slot
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        slot_q[gi] <= '0;
      end else if (arg_fire && (idx_q == IDX_W'(gi))) begin
        slot_q[gi] <= arg_data;
      end
    end
    assign k_init[gi*WIDTH +: WIDTH] = slot_q[gi];
  end

  assign arg_ready     = (state_q == LOAD);
  assign res_valid     = (state_q == DONE);
  assign busy          = (state_q != LOAD);
  assign k_r_enable    = r_en_q;
  assign k_control_arr = 1'b0;
  assign res_data      = res_data_q;
  assign res_timeout   = res_timeout_q;

endmodule

// File: doc/kernel_launcher.md
Name: kernel_launcher

Overview:
Upstream driver for an HLS-generated kernel core that uses the r_enable/w_enable start-done protocol with NARGS parallel init_* argument buses. It accepts argument words serially over a valid/ready stream and holds them stable on the kernel's argument buses. It issues a one-cycle start pulse, waits for the kernel's done edge, and returns the captured result on a valid/ready output. The kernel's own top-level is unchanged; this block replaces bench-driven stimulus in system integration.

Parameters:
WIDTH, 64, bit width of each argument and of the result
NARGS, 7, number of argument words per kernel invocation
TIMEOUT_CYCLES, 1024, maximum WAIT-state cycles before abort; used only with the optional feature

Ports:
clk  input  1  single clock; all logic on posedge
rst_n  input  1  asynchronous active-low reset
arg_valid  input  1  argument word valid
arg_ready  output  1  launcher can accept an argument word
arg_data  input  WIDTH  argument word; beat k fills slot k
k_r_enable  output  1  kernel start pulse
k_control_arr  output  1  kernel control input; constant 0
k_init  output  NARGS*WIDTH  flattened argument buses; slot k is bits [k*WIDTH +: WIDTH]
k_w_enable  input  1  kernel done indication
k_result  input  WIDTH  kernel result, valid when k_w_enable rises
res_valid  output  1  result available
res_ready  input  1  consumer accepts result
res_data  output  WIDTH  captured result
res_timeout  output  1  result aborted by watchdog; tied 0 without the optional feature
busy  output  1  high in LAUNCH, WAIT and DONE

Behaviour:
- Reset, asynchronous and active-low:
  - State is LOAD and the argument index is 0.
  - All argument slots, res_data, res_timeout and the edge-detect register are 0.
  - k_r_enable, res_valid and busy are 0.
  - arg_ready is 1 once reset is released.
- LOAD:
  - arg_ready = 1.
  - Each transfer (arg_valid && arg_ready) writes slot[idx] and increments idx.
  - The transfer with idx == NARGS-1 moves the state to LAUNCH and clears idx.
- LAUNCH:
  - Lasts exactly one cycle. k_r_enable = 1 here only; it is a registered output.
  - The last argument accepted at cycle t gives k_r_enable high at cycle t+1.
- WAIT:
  - Leaves on a rising edge of k_w_enable (k_w_enable && !prev).
  - k_result is sampled into res_data in that same cycle.
  - Next state is DONE.
- DONE:
  - res_valid = 1. res_data and res_timeout are held.
  - On res_valid && res_ready, the state returns to LOAD and arg_ready is 1 in the following cycle.
- Argument slots change only on LOAD transfers. k_init is driven directly from the slots, so it is stable from LAUNCH through DONE.
- prev updates every cycle in every state.
- Rising edges outside WAIT, and k_w_enable held high, are ignored. Exactly one capture happens per launch.
- A rising edge in the first WAIT cycle is legal (zero-latency kernel).
- Reset asserted mid-operation aborts the transaction. No result is emitted.
- NARGS = 1: the first transfer moves the state directly to LAUNCH.

Optional Feature:
KERNEL_TIMEOUT_EN
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entering WAIT and increments each WAIT cycle.
  - When it reaches TIMEOUT_CYCLES with no edge, the state moves to DONE with res_data = 0 and res_timeout = 1.
  - A done edge in the same cycle as expiry wins: the result is captured and res_timeout = 0.
  - res_timeout clears on entering LOAD.
- Undefined: WAIT lasts indefinitely, no counter is built, and res_timeout is constant 0.

Decomposition:
- Package kernel_launcher_pkg holds:
  - the state enum (LOAD, LAUNCH, WAIT, DONE);
  - default WIDTH and NARGS localparams;
  - an index-width helper, $clog2(NARGS) with a minimum of 1.
- One sub-module, launcher_edge_det: a registered rising-edge detector on k_w_enable with asynchronous active-low reset.

Test Plan:
1. Nominal add7: the bench kernel model sums its slots and raises w_enable 3 cycles after r_enable.
   - Stimulus: 123, 234, 345, 456, 567, 678, 789 sent back-to-back.
   - Required: a single k_r_enable pulse one cycle after the 7th beat, then res_valid with res_data = 3192.
2. Backpressure:
   - Stimulus: res_ready low for 10 cycles, then high.
   - Required: res_valid, res_data = 3192, busy = 1 and arg_ready = 0 all hold while res_ready is low; arg_ready rises the cycle after the handshake.
3. Gapped input:
   - Stimulus: 0–5 idle cycles inserted between the seven beats.
   - Required: no k_r_enable before the 7th transfer; result still 3192.
4. Spurious done:
   - Stimulus: k_w_enable pulsed during LOAD, then held high for 5 cycles in WAIT.
   - Required: the LOAD pulse is ignored; exactly one capture and one res_valid transaction.
5. Reset mid-WAIT:
   - Stimulus: rst_n low for 2 cycles during WAIT.
   - Required: all outputs return to reset values immediately (asynchronous); the next full add7 transaction returns 3192.
6. Timeout (KERNEL_TIMEOUT_EN defined, TIMEOUT_CYCLES = 16):
   - Stimulus: the kernel model never responds.
   - Required: res_valid rises 16 WAIT cycles after entering WAIT, with res_timeout = 1 and res_data = 0.
   - With the macro undefined: res_valid stays 0 for 200 cycles.
